// File: rtl/issue_queue.sv
// issue_queue: age-ordered issue queue with CDB wakeup and single-issue select.
// Entries are compacted by shifting so entry 0 is always the oldest.
// Optional feature macro: ISSUE_CDB_BYPASS_EN. When defined, an entry whose only
// missing operands match the current CDB broadcast issues in that same cycle,
// with cdb_data forwarded onto the issue operand bus.
module issue_queue #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int NUM_AU  = 3,
    parameter int NUM_MUL = 3,
    localparam int MAX_U  = (NUM_AU > NUM_MUL) ? NUM_AU : NUM_MUL,
    localparam int UNIT_W = (MAX_U > 1) ? $clog2(MAX_U) : 1,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               flush_i,
    input  logic               enq_valid_i,
    output logic               enq_ready_o,
    input  logic [1:0]         enq_fu_i,
    input  logic [TAG_W-1:0]   enq_tag_i,
    input  logic               enq_rs1_valid_i,
    input  logic [31:0]        enq_rs1_data_i,
    input  logic [TAG_W-1:0]   enq_rs1_tag_i,
    input  logic               enq_rs2_valid_i,
    input  logic [31:0]        enq_rs2_data_i,
    input  logic [TAG_W-1:0]   enq_rs2_tag_i,
    input  logic               cdb_valid_i,
    input  logic [TAG_W-1:0]   cdb_tag_i,
    input  logic [31:0]        cdb_data_i,
    input  logic [NUM_AU-1:0]  au_free_i,
    input  logic [NUM_MUL-1:0] mul_free_i,
    input  logic               lsu_free_i,
    output logic               iss_valid_o,
    output logic [1:0]         iss_fu_o,
    output logic [UNIT_W-1:0]  iss_unit_o,
    output logic [TAG_W-1:0]   iss_tag_o,
    output logic [31:0]        iss_rs1_o,
    output logic [31:0]        iss_rs2_o,
    output logic [CNT_W-1:0]   count_o
);

    localparam int IDX_W = $clog2(DEPTH);

`ifdef ISSUE_CDB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct packed {
        logic             valid;
        logic [1:0]       fu;
        logic [TAG_W-1:0] tag;
        logic             rs1_v;
        logic [TAG_W-1:0] rs1_t;
        logic [31:0]      rs1_d;
        logic             rs2_v;
        logic [TAG_W-1:0] rs2_t;
        logic [31:0]      rs2_d;
    } entry_t;

    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    entry_t           woke  [DEPTH];
    entry_t           new_ent;
    logic [CNT_W-1:0] count_q, count_d;

    logic [DEPTH-1:0] byp1, byp2, ready;
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic [UNIT_W-1:0] sel_unit;
    logic             issue, accept;
    logic [CNT_W-1:0] enq_pos;

    assign enq_ready_o = (count_q < CNT_W'(DEPTH)) && !flush_i && rst_n_i;
    assign accept      = enq_valid_i && enq_ready_o && (enq_fu_i != 2'd3);
    assign issue       = iss_valid_o;
    assign count_o     = count_q;

    // Per-entry readiness: operands present (or arriving on the CDB when bypass is on) and a free unit of its class.
    always_comb begin
        byp1  = '0;
        byp2  = '0;
        ready = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic cls_free;
            cls_free = 1'b0;
            byp1[i] = BYPASS && cdb_valid_i && !ent_q[i].rs1_v && (ent_q[i].rs1_t == cdb_tag_i);
            byp2[i] = BYPASS && cdb_valid_i && !ent_q[i].rs2_v && (ent_q[i].rs2_t == cdb_tag_i);
            case (ent_q[i].fu)
                2'd0:    cls_free = |au_free_i;
                2'd1:    cls_free = |mul_free_i;
                2'd2:    cls_free = lsu_free_i;
                default: cls_free = 1'b0;
            endcase
            ready[i] = ent_q[i].valid && cls_free
                     && (ent_q[i].rs1_v || byp1[i]) && (ent_q[i].rs2_v || byp2[i]);
        end
    end

    // Oldest-first select: lowest index ready entry wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ready[i] && !sel_found) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    // Unit pick: lowest free unit of the selected class; the single LSU is always unit 0.
    always_comb begin
        logic found;
        found    = 1'b0;
        sel_unit = '0;
        case (ent_q[sel_idx].fu)
            2'd0: begin
                for (int j = 0; j < NUM_AU; j++) begin
                    if (au_free_i[j] && !found) begin
                        found    = 1'b1;
                        sel_unit = UNIT_W'(j);
                    end
                end
            end
            2'd1: begin
                for (int j = 0; j < NUM_MUL; j++) begin
                    if (mul_free_i[j] && !found) begin
                        found    = 1'b1;
                        sel_unit = UNIT_W'(j);
                    end
                end
            end
            default: sel_unit = '0;
        endcase
    end

    // Issue bus: zeroed whenever nothing issues so downstream never sees stale payload.
    always_comb begin
        iss_valid_o = sel_found && !flush_i;
        iss_fu_o    = '0;
        iss_unit_o  = '0;
        iss_tag_o   = '0;
        iss_rs1_o   = '0;
        iss_rs2_o   = '0;
        if (iss_valid_o) begin
            iss_fu_o   = ent_q[sel_idx].fu;
            iss_unit_o = sel_unit;
            iss_tag_o  = ent_q[sel_idx].tag;
            iss_rs1_o  = byp1[sel_idx] ? cdb_data_i : ent_q[sel_idx].rs1_d;
            iss_rs2_o  = byp2[sel_idx] ? cdb_data_i : ent_q[sel_idx].rs2_d;
        end
    end

    // Next queue contents: wakeup, remove-and-shift on issue, append on accept, flush wipes all.
    always_comb begin
        new_ent       = '0;
        new_ent.valid = 1'b1;
        new_ent.fu    = enq_fu_i;
        new_ent.tag   = enq_tag_i;
        new_ent.rs1_t = enq_rs1_tag_i;
        new_ent.rs2_t = enq_rs2_tag_i;
        new_ent.rs1_v = enq_rs1_valid_i;
        new_ent.rs1_d = enq_rs1_data_i;
        new_ent.rs2_v = enq_rs2_valid_i;
        new_ent.rs2_d = enq_rs2_data_i;
        if (cdb_valid_i && !enq_rs1_valid_i && (enq_rs1_tag_i == cdb_tag_i)) begin
            new_ent.rs1_v = 1'b1;
            new_ent.rs1_d = cdb_data_i;
        end
        if (cdb_valid_i && !enq_rs2_valid_i && (enq_rs2_tag_i == cdb_tag_i)) begin
            new_ent.rs2_v = 1'b1;
            new_ent.rs2_d = cdb_data_i;
        end

        for (int i = 0; i < DEPTH; i++) begin
            woke[i] = ent_q[i];
            if (cdb_valid_i && !ent_q[i].rs1_v && (ent_q[i].rs1_t == cdb_tag_i)) begin
                woke[i].rs1_v = 1'b1;
                woke[i].rs1_d = cdb_data_i;
            end
            if (cdb_valid_i && !ent_q[i].rs2_v && (ent_q[i].rs2_t == cdb_tag_i)) begin
                woke[i].rs2_v = 1'b1;
                woke[i].rs2_d = cdb_data_i;
            end
        end

        for (int i = 0; i < DEPTH - 1; i++) begin
            ent_d[i] = (issue && (i >= int'(sel_idx))) ? woke[i+1] : woke[i];
        end
        ent_d[DEPTH-1] = issue ? '0 : woke[DEPTH-1];

        enq_pos = count_q - CNT_W'(issue);
        for (int i = 0; i < DEPTH; i++) begin
            if (accept && (enq_pos == CNT_W'(i))) ent_d[i] = new_ent;
        end

        count_d = count_q + CNT_W'(accept) - CNT_W'(issue);

        if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
            count_d = '0;
        end
    end

    // Queue state registers; reset discards everything immediately.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue at default parameters (DEPTH=4, TAG_W=4, 3 AU, 3 MUL).
// Inputs change 1ns after the rising edge; outputs are checked on the falling edge.
module tb_issue_queue;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        flush_i;
    logic        enq_valid_i;
    logic        enq_ready_o;
    logic [1:0]  enq_fu_i;
    logic [3:0]  enq_tag_i;
    logic        enq_rs1_valid_i;
    logic [31:0] enq_rs1_data_i;
    logic [3:0]  enq_rs1_tag_i;
    logic        enq_rs2_valid_i;
    logic [31:0] enq_rs2_data_i;
    logic [3:0]  enq_rs2_tag_i;
    logic        cdb_valid_i;
    logic [3:0]  cdb_tag_i;
    logic [31:0] cdb_data_i;
    logic [2:0]  au_free_i;
    logic [2:0]  mul_free_i;
    logic        lsu_free_i;
    logic        iss_valid_o;
    logic [1:0]  iss_fu_o;
    logic [1:0]  iss_unit_o;
    logic [3:0]  iss_tag_o;
    logic [31:0] iss_rs1_o;
    logic [31:0] iss_rs2_o;
    logic [2:0]  count_o;

    int checks   = 0;
    int failures = 0;

    issue_queue dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
        .enq_valid_i(enq_valid_i), .enq_ready_o(enq_ready_o), .enq_fu_i(enq_fu_i),
        .enq_tag_i(enq_tag_i),
        .enq_rs1_valid_i(enq_rs1_valid_i), .enq_rs1_data_i(enq_rs1_data_i), .enq_rs1_tag_i(enq_rs1_tag_i),
        .enq_rs2_valid_i(enq_rs2_valid_i), .enq_rs2_data_i(enq_rs2_data_i), .enq_rs2_tag_i(enq_rs2_tag_i),
        .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i), .cdb_data_i(cdb_data_i),
        .au_free_i(au_free_i), .mul_free_i(mul_free_i), .lsu_free_i(lsu_free_i),
        .iss_valid_o(iss_valid_o), .iss_fu_o(iss_fu_o), .iss_unit_o(iss_unit_o),
        .iss_tag_o(iss_tag_o), .iss_rs1_o(iss_rs1_o), .iss_rs2_o(iss_rs2_o),
        .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_enq(input logic [1:0] fu, input logic [3:0] tag,
                           input logic v1, input logic [31:0] d1, input logic [3:0] t1,
                           input logic v2, input logic [31:0] d2, input logic [3:0] t2);
        enq_valid_i     = 1'b1;
        enq_fu_i        = fu;
        enq_tag_i       = tag;
        enq_rs1_valid_i = v1;
        enq_rs1_data_i  = d1;
        enq_rs1_tag_i   = t1;
        enq_rs2_valid_i = v2;
        enq_rs2_data_i  = d2;
        enq_rs2_tag_i   = t2;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0; flush_i = 1'b0; enq_valid_i = 1'b0;
        set_enq(2'd0, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0);
        enq_valid_i = 1'b0;
        cdb_valid_i = 1'b0; cdb_tag_i = '0; cdb_data_i = '0;
        au_free_i = '0; mul_free_i = '0; lsu_free_i = 1'b0;
        #2;
        checks++; if (count_o !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count_o); end
        checks++; if (iss_valid_o !== 1'b0) begin failures++; $display("FAIL reset_iss_valid got=%0b exp=0", iss_valid_o); end
        checks++; if (enq_ready_o !== 1'b0) begin failures++; $display("FAIL reset_enq_ready got=%0b exp=0", enq_ready_o); end
        checks++; if (iss_tag_o !== 4'd0 || iss_rs1_o !== 32'd0) begin failures++; $display("FAIL reset_iss_zero tag=%0d rs1=%0d exp=0", iss_tag_o, iss_rs1_o); end
        @(posedge clk_i); tick();
        rst_n_i = 1'b1;
    endtask

    task automatic test_basic();
        au_free_i = 3'b111;
        set_enq(2'd0, 4'd1, 1'b1, 32'd10, 4'd0, 1'b1, 32'd10, 4'd0);
        @(negedge clk_i);
        checks++; if (enq_ready_o !== 1'b1) begin failures++; $display("FAIL basic_ready got=%0b exp=1", enq_ready_o); end
        checks++; if (iss_valid_o !== 1'b0) begin failures++; $display("FAIL basic_pre_iss got=%0b exp=0", iss_valid_o); end
        tick();
        enq_valid_i = 1'b0;
        @(negedge clk_i);
        checks++; if (count_o !== 3'd1) begin failures++; $display("FAIL basic_count1 got=%0d exp=1", count_o); end
        checks++; if (iss_valid_o !== 1'b1) begin failures++; $display("FAIL basic_iss_valid got=%0b exp=1", iss_valid_o); end
        checks++; if (iss_fu_o !== 2'd0 || iss_unit_o !== 2'd0) begin failures++; $display("FAIL basic_fu_unit fu=%0d unit=%0d exp=0/0", iss_fu_o, iss_unit_o); end
        checks++; if (iss_rs1_o !== 32'd10 || iss_rs2_o !== 32'd10) begin failures++; $display("FAIL basic_ops rs1=%0d rs2=%0d exp=10/10", iss_rs1_o, iss_rs2_o); end
        checks++; if (iss_tag_o !== 4'd1) begin failures++; $display("FAIL basic_tag got=%0d exp=1", iss_tag_o); end
        tick();
        @(negedge clk_i);
        checks++; if (count_o !== 3'd0) begin failures++; $display("FAIL basic_count0 got=%0d exp=0", count_o); end
        checks++; if (iss_valid_o !== 1'b0 || iss_tag_o !== 4'd0) begin failures++; $display("FAIL basic_idle valid=%0b tag=%0d exp=0/0", iss_valid_o, iss_tag_o); end
        tick();
    endtask

    task automatic test_wakeup();
        au_free_i = 3'b111;
        set_enq(2'd0, 4'd2, 1'b0, 32'd0, 4'd5, 1'b1, 32'd10, 4'd0);
        tick();
        enq_valid_i = 1'b0;
        cdb_valid_i = 1'b1; cdb_tag_i = 4'd5; cdb_data_i = 32'd7;
        @(negedge clk_i);
`ifdef ISSUE_CDB_BYPASS_EN
        checks++; if (iss_valid_o !== 1'b1 || iss_rs1_o !== 32'd7) begin failures++; $display("FAIL wake_bypass valid=%0b rs1=%0d exp=1/7", iss_valid_o, iss_rs1_o); end
`else
        checks++; if (iss_valid_o !== 1'b0) begin failures++; $display("FAIL wake_early valid=%0b exp=0", iss_valid_o); end
`endif
        tick();
        cdb_valid_i = 1'b0; cdb_tag_i = '0; cdb_data_i = '0;
        @(negedge clk_i);
`ifdef ISSUE_CDB_BYPASS_EN
        checks++; if (count_o !== 3'd0 || iss_valid_o !== 1'b0) begin failures++; $display("FAIL wake_after count=%0d valid=%0b exp=0/0", count_o, iss_valid_o); end
`else
        checks++; if (iss_valid_o !== 1'b1 || iss_rs1_o !== 32'd7 || iss_rs2_o !== 32'd10) begin failures++; $display("FAIL wake_late valid=%0b rs1=%0d rs2=%0d exp=1/7/10", iss_valid_o, iss_rs1_o, iss_rs2_o); end
`endif
        tick();
        @(negedge clk_i);
        checks++; if (count_o !== 3'd0) begin failures++; $display("FAIL wake_drain got=%0d exp=0", count_o); end
        tick();
    endtask

    task automatic test_full();
        au_free_i = 3'b000; mul_free_i = 3'b000;
        for (int i = 0; i < 4; i++) begin
            set_enq(2'd1, 4'(i + 1), 1'b1, 32'(100 + i), 4'd0, 1'b1, 32'd3, 4'd0);
            @(negedge clk_i);
            checks++; if (enq_ready_o !== 1'b1) begin failures++; $display("FAIL full_ready%0d got=%0b exp=1", i, enq_ready_o); end
            tick();
        end
        enq_valid_i = 1'b0;
        @(negedge clk_i);
        checks++; if (count_o !== 3'd4 || enq_ready_o !== 1'b0) begin failures++; $display("FAIL full_state count=%0d ready=%0b exp=4/0", count_o, enq_ready_o); end
        checks++; if (iss_valid_o !== 1'b0) begin failures++; $display("FAIL full_noiss got=%0b exp=0", iss_valid_o); end
        tick();
        mul_free_i = 3'b100;
        @(negedge clk_i);
        checks++; if (iss_valid_o !== 1'b1 || iss_unit_o !== 2'd2 || iss_tag_o !== 4'd1 || iss_fu_o !== 2'd1) begin
            failures++; $display("FAIL full_issue valid=%0b unit=%0d tag=%0d fu=%0d exp=1/2/1/1", iss_valid_o, iss_unit_o, iss_tag_o, iss_fu_o); end
        checks++; if (enq_ready_o !== 1'b0) begin failures++; $display("FAIL full_nocredit got=%0b exp=0", enq_ready_o); end
        tick();
        mul_free_i = 3'b000;
        @(negedge clk_i);
        checks++; if (count_o !== 3'd3 || enq_ready_o !== 1'b1) begin failures++; $display("FAIL full_after count=%0d ready=%0b exp=3/1", count_o, enq_ready_o); end
        tick();
        mul_free_i = 3'b010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            checks++; if (iss_valid_o !== 1'b1 || iss_tag_o !== 4'(i + 2) || iss_unit_o !== 2'd1 || iss_rs1_o !== 32'(101 + i)) begin
                failures++; $display("FAIL full_drain%0d valid=%0b tag=%0d unit=%0d rs1=%0d exp=1/%0d/1/%0d", i, iss_valid_o, iss_tag_o, iss_unit_o, iss_rs1_o, i + 2, 101 + i); end
            tick();
        end
        mul_free_i = 3'b000;
        @(negedge clk_i);
        checks++; if (count_o !== 3'd0) begin failures++; $display("FAIL full_empty got=%0d exp=0", count_o); end
        tick();
    endtask

    task automatic test_out_of_order();
        au_free_i = 3'b111; mul_free_i = 3'b000;
        set_enq(2'd1, 4'd6, 1'b1, 32'd60, 4'd0, 1'b1, 32'd61, 4'd0);
        tick();
        set_enq(2'd0, 4'd7, 1'b1, 32'd70, 4'd0, 1'b1, 32'd71, 4'd0);
        tick();
        enq_valid_i = 1'b0;
        @(negedge clk_i);
        checks++; if (count_o !== 3'd2 || iss_valid_o !== 1'b1 || iss_tag_o !== 4'd7) begin
            failures++; $display("FAIL ooo_young count=%0d valid=%0b tag=%0d exp=2/1/7", count_o, iss_valid_o, iss_tag_o); end
        tick();
        @(negedge clk_i);
        checks++; if (count_o !== 3'd1 || iss_valid_o !== 1'b0) begin failures++; $display("FAIL ooo_left count=%0d valid=%0b exp=1/0", count_o, iss_valid_o); end
        tick();
    endtask

    task automatic test_back_to_back();
        // Old MUL entry issues while a new AU entry enqueues; the newcomer must land at index 0.
        mul_free_i = 3'b001; au_free_i = 3'b110;
        set_enq(2'd0, 4'd8, 1'b1, 32'd80, 4'd0, 1'b1, 32'd81, 4'd0);
        @(negedge clk_i);
        checks++; if (iss_valid_o !== 1'b1 || iss_tag_o !== 4'd6 || iss_fu_o !== 2'd1 || iss_unit_o !== 2'd0 || iss_rs2_o !== 32'd61) begin
            failures++; $display("FAIL b2b_old valid=%0b tag=%0d fu=%0d unit=%0d rs2=%0d exp=1/6/1/0/61", iss_valid_o, iss_tag_o, iss_fu_o, iss_unit_o, iss_rs2_o); end
        tick();
        enq_valid_i = 1'b0; mul_free_i = 3'b000;
        @(negedge clk_i);
        checks++; if (count_o !== 3'd1 || iss_valid_o !== 1'b1 || iss_tag_o !== 4'd8 || iss_unit_o !== 2'd1) begin
            failures++; $display("FAIL b2b_new count=%0d valid=%0b tag=%0d unit=%0d exp=1/1/8/1", count_o, iss_valid_o, iss_tag_o, iss_unit_o); end
        tick();
        set_enq(2'd3, 4'd9, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0);
        tick();
        enq_valid_i = 1'b0;
        @(negedge clk_i);
        checks++; if (count_o !== 3'd0 || iss_valid_o !== 1'b0) begin failures++; $display("FAIL illegal_drop count=%0d valid=%0b exp=0/0", count_o, iss_valid_o); end
        tick();
    endtask

    task automatic test_flush();
        au_free_i = 3'b000; mul_free_i = 3'b000; lsu_free_i = 1'b0;
        set_enq(2'd0, 4'd1, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0); tick();
        set_enq(2'd1, 4'd2, 1'b1, 32'd2, 4'd0, 1'b1, 32'd2, 4'd0); tick();
        set_enq(2'd2, 4'd3, 1'b1, 32'd3, 4'd0, 1'b1, 32'd4, 4'd0); tick();
        enq_valid_i = 1'b0;
        lsu_free_i = 1'b1;
        @(negedge clk_i);
        checks++; if (count_o !== 3'd3 || iss_valid_o !== 1'b1 || iss_fu_o !== 2'd2 || iss_unit_o !== 2'd0 || iss_tag_o !== 4'd3) begin
            failures++; $display("FAIL flush_pre count=%0d valid=%0b fu=%0d unit=%0d tag=%0d exp=3/1/2/0/3", count_o, iss_valid_o, iss_fu_o, iss_unit_o, iss_tag_o); end
        #1;
        flush_i = 1'b1;
        set_enq(2'd0, 4'd5, 1'b1, 32'd5, 4'd0, 1'b1, 32'd5, 4'd0);
        #1;
        checks++; if (iss_valid_o !== 1'b0 || enq_ready_o !== 1'b0 || iss_tag_o !== 4'd0) begin
            failures++; $display("FAIL flush_cycle valid=%0b ready=%0b tag=%0d exp=0/0/0", iss_valid_o, enq_ready_o, iss_tag_o); end
        tick();
        flush_i = 1'b0; enq_valid_i = 1'b0; au_free_i = 3'b111;
        @(negedge clk_i);
        checks++; if (count_o !== 3'd0 || iss_valid_o !== 1'b0) begin failures++; $display("FAIL flush_after count=%0d valid=%0b exp=0/0", count_o, iss_valid_o); end
        tick();
        lsu_free_i = 1'b0;
    endtask

    task automatic test_async_reset();
        au_free_i = 3'b000; mul_free_i = 3'b000;
        set_enq(2'd0, 4'd9, 1'b1, 32'd90, 4'd0, 1'b1, 32'd91, 4'd0); tick();
        set_enq(2'd0, 4'd10, 1'b1, 32'd100, 4'd0, 1'b1, 32'd101, 4'd0); tick();
        set_enq(2'd0, 4'd11, 1'b1, 32'd110, 4'd0, 1'b1, 32'd111, 4'd0);
        @(negedge clk_i);
        checks++; if (count_o !== 3'd2) begin failures++; $display("FAIL arst_pre got=%0d exp=2", count_o); end
        #1;
        au_free_i = 3'b111;
        #1;
        checks++; if (iss_valid_o !== 1'b1 || iss_tag_o !== 4'd9) begin failures++; $display("FAIL arst_iss valid=%0b tag=%0d exp=1/9", iss_valid_o, iss_tag_o); end
        rst_n_i = 1'b0;
        #1;
        checks++; if (count_o !== 3'd0 || iss_valid_o !== 1'b0 || enq_ready_o !== 1'b0) begin
            failures++; $display("FAIL arst_now count=%0d valid=%0b ready=%0b exp=0/0/0", count_o, iss_valid_o, enq_ready_o); end
        tick();
        enq_valid_i = 1'b0;
        rst_n_i = 1'b1;
        @(negedge clk_i);
        checks++; if (count_o !== 3'd0 || iss_valid_o !== 1'b0 || enq_ready_o !== 1'b1) begin
            failures++; $display("FAIL arst_after count=%0d valid=%0b ready=%0b exp=0/0/1", count_o, iss_valid_o, enq_ready_o); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wakeup();
        test_full();
        test_out_of_order();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
